// File: rtl/mult_div_ctrl_if.sv
// Request/response bundle between the main control unit and the mult/div sequencer.
// The control side (master) issues operands; the sequencer (slave) returns status and HI/LO.
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic             o_hi_lo_write;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_div_zero_exc;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_hi_lo_write, o_hi, o_lo, o_div_zero_exc
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_hi_lo_write, o_hi, o_lo, o_div_zero_exc
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) sequencer
// producing HI/LO one bit per cycle; divide by zero yields a one-cycle exception pulse.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE, S_EXC} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH:0]   r_acc_hi;
    logic [WIDTH-1:0]        r_acc_lo;
    logic signed [WIDTH:0]   r_m;
    logic                    r_q1;
    logic                    r_op;
    logic                    r_sign_a;
    logic                    r_sign_b;
    logic [WIDTH-1:0]        r_hi;
    logic [WIDTH-1:0]        r_lo;
    logic signed [WIDTH:0]   w_addend;
    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH:0]   w_r_sh;
    logic signed [WIDTH:0]   w_trial;
    logic                    w_last;

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    // 0x80..0 maps to itself and is then read as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_val(v) : v;
    endfunction

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_addend = '0;
        case ({r_acc_lo[0], r_q1})
            2'b01:   w_addend = r_m;
            2'b10:   w_addend = -r_m;
            default: w_addend = '0;
        endcase
        w_sum   = r_acc_hi + w_addend;
        w_r_sh  = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
        w_trial = w_r_sh - r_m;
    end

    always_comb begin
        w_next             = r_state;
        bus.o_busy         = 1'b0;
        bus.o_done         = 1'b0;
        bus.o_hi_lo_write  = 1'b0;
        bus.o_div_zero_exc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (!bus.i_op)            w_next = S_MUL;
                    else if (bus.i_b == '0)   w_next = S_EXC;
                    else                      w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                bus.o_busy = 1'b1;
                if (w_last) w_next = S_FIX;
            end
            S_FIX: begin
                bus.o_busy = 1'b1;
                w_next     = S_DONE;
            end
            S_DONE: begin
                bus.o_busy        = 1'b1;
                bus.o_done        = 1'b1;
                bus.o_hi_lo_write = 1'b1;
                w_next            = S_IDLE;
            end
            S_EXC: begin
                bus.o_div_zero_exc = 1'b1;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_state == S_MUL || r_state == S_DIV) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_FIX) begin
                if (!r_op) begin
                    r_hi <= r_acc_hi[WIDTH-1:0];
                    r_lo <= r_acc_lo;
                end else begin
                    r_hi <= r_sign_a ? neg_val(r_acc_hi[WIDTH-1:0]) : r_acc_hi[WIDTH-1:0];
                    r_lo <= (r_sign_a ^ r_sign_b) ? neg_val(r_acc_lo) : r_acc_lo;
                end
            end
        end
    end

    // Shared accumulator: MUL uses {P_hi(+guard), P_lo, q-1}; DIV uses {R, Q} with r_m = |b|.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    r_op     <= bus.i_op;
                    r_q1     <= 1'b0;
                    r_acc_hi <= '0;
                    r_sign_a <= bus.i_a[WIDTH-1];
                    r_sign_b <= bus.i_b[WIDTH-1];
                    if (!bus.i_op) begin
                        r_acc_lo <= bus.i_a;
                        r_m      <= {bus.i_b[WIDTH-1], bus.i_b};
                    end else begin
                        r_acc_lo <= abs_val(bus.i_a);
                        r_m      <= {1'b0, abs_val(bus.i_b)};
                    end
                end
            end
            S_MUL: begin
                r_acc_hi <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                r_q1     <= r_acc_lo[0];
            end
            S_DIV: begin
                if (!w_trial[WIDTH]) begin
                    r_acc_hi <= w_trial;
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc_hi <= w_r_sh;
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    assign bus.o_hi = r_hi;
    assign bus.o_lo = r_lo;
endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Iterative signed multiply/divide sequencer for the multicycle CPU; owns the mult/div resource feeding regHI/regLO.
- Main control issues a start with operands from regA/regB; the block iterates one bit per cycle, then pulses hi_lo_write so HI/LO load in the same cycle.
- Division by zero raises a one-cycle exception pulse to the control unit instead of a result.

Parameters:
- WIDTH, 32, operand width; iteration count = WIDTH; HI/LO are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MULT (signed), 1 = DIV (signed)
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse; hi/lo valid
- hi_lo_write  out  1  one-cycle pulse, same cycle as done; drives ctrl_hi/ctrl_lo load
- hi  out  WIDTH  MULT: product[63:32]; DIV: remainder
- lo  out  WIDTH  MULT: product[31:0]; DIV: quotient
- div_zero_exc  out  1  one-cycle pulse on DIV with b == 0

Behaviour:
- Reset (reset == 0 at a clk edge): state = IDLE; busy, done, hi_lo_write, div_zero_exc, hi, lo and the iteration counter all 0. Reset overrides everything, including mid-operation; any partial result is discarded.
- States: IDLE, MUL, DIV, FIX, DONE, EXC.
- IDLE:
  - start = 1, op = 0: latch a, b; enter MUL.
  - start = 1, op = 1, b != 0: latch |a|, |b| and both sign bits; enter DIV.
  - start = 1, op = 1, b == 0: enter EXC.
  - start = 0: stay in IDLE.
- MUL: radix-2 Booth; one step per cycle for WIDTH cycles.
  - 2*WIDTH+1-bit accumulator {P_hi, P_lo, q-1}.
  - Each step adds +b, -b or 0 to P_hi according to {P_lo[0], q-1}, then arithmetic-shifts right by 1.
  - Counter counts 0..WIDTH-1; then enter FIX.
- DIV: restoring, unsigned on magnitudes, one quotient bit per cycle for WIDTH cycles.
  - Shift {R, Q} left by 1; trial R - |b|.
  - If non-negative: keep the difference, Q[0] = 1; else restore R, Q[0] = 0.
  - After WIDTH steps, enter FIX.
- FIX (1 cycle):
  - MULT: pass the product through.
  - DIV: negate the quotient if sign(a) != sign(b); negate the remainder if sign(a) = 1. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Load hi/lo registers.
- DONE (1 cycle): done = 1, hi_lo_write = 1, busy = 1; next state IDLE.
- EXC (1 cycle): div_zero_exc = 1; done = 0, hi_lo_write = 0; hi/lo keep previous values; busy = 0; next state IDLE.
- Latency, with the accept edge as cycle 0:
  - Iterations run in cycles 1..WIDTH; FIX is cycle WIDTH+1; done is visible in cycle WIDTH+2 (cycle 34 for WIDTH = 32).
  - EXC pulse is visible in cycle 1.
- busy is 1 in MUL, DIV, FIX and DONE; 0 in IDLE and EXC.
- start while busy is ignored (no queueing); start coincident with DONE is ignored; a new start is accepted only in IDLE.
- Operands are latched at accept; changes on a/b/op afterwards have no effect.
- Arithmetic edge cases:
  - -2^(W-1) / -1: lo = 0x80000000, hi = 0, no exception. The magnitude 0x80000000 is treated as unsigned, and its negation wraps to itself.
  - -2^(W-1) * -2^(W-1): hi = 0x40000000, lo = 0. The Booth accumulator needs one guard bit for this case.
- hi/lo hold their last result until the next DONE or reset.

Test Plan:
- MULT a = 7, b = 0xFFFFFFFD (-3) -> cycle 34: done = 1, hi_lo_write = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy in cycles 1-34, 0 in cycle 35.
- MULT a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000; also MULT 0x0001_0000 * 0x0001_0000 -> hi = 1, lo = 0.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIV a = 100, b = 7 -> lo = 14, hi = 2; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV with b = 0 after a prior result hi = 2, lo = 14 -> cycle 1: div_zero_exc = 1, done = 0, hi_lo_write = 0; hi/lo stay 2/14; cycle 2 back in IDLE, and a new start is accepted.
- start pulsed in cycle 10 of a MULT with different operands -> ignored; the original result is delivered at cycle 34 and only one done pulse occurs.
- reset = 0 in cycle 15 of a DIV -> next edge: busy = done = hi = lo = 0, IDLE; no done pulse follows; a new DIV afterwards completes correctly.
